// File: rtl/maze_pkg.sv
// Shared maze geometry, probe directions and scheduler state encoding
// for the maze wall-probe scheduler.
package maze_pkg;

  localparam int unsigned MAP_COLS   = 28;
  localparam int unsigned MAP_ROWS   = 31;
  localparam int unsigned TILE_SHIFT = 4;
  localparam logic [4:0]  WALL       = 5'h1F;

  typedef enum logic [1:0] {
    DIR_L,
    DIR_R,
    DIR_B,
    DIR_T
  } probe_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/maze_probe_sched_if.sv
// Maze ROM read port: address/strobe out, tile code back one cycle later.
interface maze_probe_sched_if;

  logic [9:0] rom_addr;
  logic       rom_rd;
  logic [4:0] rom_data;

  modport master (output rom_addr, output rom_rd, input rom_data);
  modport slave  (input rom_addr, input rom_rd, output rom_data);

endinterface

// File: rtl/maze_probe_addr.sv
// Combinational probe-pixel to tile-address mapping with maze range check.
module maze_probe_addr
  import maze_pkg::*;
#(
  parameter int unsigned PROBE_OFS = 14
) (
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  probe_dir_e  dir,
  output logic [9:0]  addr,
  output logic        in_range
);

  logic [10:0] px;
  logic [10:0] py;
  logic        under;

  always_comb begin
    px    = {1'b0, x};
    py    = {1'b0, y};
    under = 1'b0;
    unique case (dir)
      DIR_L: begin
        px    = {1'b0, x} - 11'(PROBE_OFS);
        under = (x < 10'(PROBE_OFS));
      end
      DIR_R: px = {1'b0, x} + 11'(PROBE_OFS);
      DIR_B: py = {1'b0, y} + 11'(PROBE_OFS);
      DIR_T: begin
        py    = {1'b0, y} - 11'(PROBE_OFS);
        under = (y < 10'(PROBE_OFS));
      end
    endcase

    in_range = !under
             && (px < 11'(MAP_COLS << TILE_SHIFT))
             && (py < 11'(MAP_ROWS << TILE_SHIFT));
    addr = 10'(16'(py >> TILE_SHIFT) * 16'(MAP_COLS) + 16'(px >> TILE_SHIFT));
  end

endmodule

// File: rtl/maze_probe_sched.sv
// Per-frame wall-probe scheduler: snapshots mover positions, reads four
// neighbour tiles per mover from the shared maze ROM, commits them atomically.
module maze_probe_sched
  import maze_pkg::*;
#(
  parameter int unsigned N_MOVERS  = 5,
  parameter int unsigned PROBE_OFS = 14
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_start,
  input  logic [N_MOVERS-1:0][9:0] pos_x,
  input  logic [N_MOVERS-1:0][9:0] pos_y,
  maze_probe_sched_if.master       rom,
  output logic [N_MOVERS-1:0][4:0] map_l,
  output logic [N_MOVERS-1:0][4:0] map_r,
  output logic [N_MOVERS-1:0][4:0] map_b,
  output logic [N_MOVERS-1:0][4:0] map_t,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int unsigned N_PROBES = 4 * N_MOVERS;
  localparam int unsigned IDX_W    = $clog2(N_PROBES);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_MOVERS-1:0][9:0]  snap_x_q, snap_x_d;
  logic [N_MOVERS-1:0][9:0]  snap_y_q, snap_y_d;
  logic [IDX_W-1:0]          prb_idx_q, prb_idx_d;
  logic                      prb_vld_q, prb_vld_d;
  logic                      prb_rng_q, prb_rng_d;
  logic [N_PROBES-1:0][4:0]  shadow_q, shadow_d;
  logic [N_MOVERS-1:0][4:0]  map_l_q, map_l_d, map_r_q, map_r_d;
  logic [N_MOVERS-1:0][4:0]  map_b_q, map_b_d, map_t_q, map_t_d;
  logic                      done_q, done_d;
  logic                      overrun_q, overrun_d;

  logic [IDX_W-3:0]          cur_mover;
  probe_dir_e                cur_dir;
  logic [9:0]                probe_addr;
  logic                      probe_in_range;

  always_comb begin
    cur_mover = idx_q[IDX_W-1:2];
    cur_dir   = probe_dir_e'(idx_q[1:0]);
  end

  maze_probe_addr #(
    .PROBE_OFS (PROBE_OFS)
  ) u_addr (
    .x        (snap_x_q[cur_mover]),
    .y        (snap_y_q[cur_mover]),
    .dir      (cur_dir),
    .addr     (probe_addr),
    .in_range (probe_in_range)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    prb_vld_d    = 1'b0;
    prb_idx_d    = idx_q;
    prb_rng_d    = probe_in_range;
    shadow_d     = shadow_q;
    map_l_d      = map_l_q;
    map_r_d      = map_r_q;
    map_b_d      = map_b_q;
    map_t_d      = map_t_q;
    done_d       = 1'b0;
    busy         = (state_q != ST_IDLE);
    overrun_d    = frame_start && busy;
    rom.rom_rd   = 1'b0;
    rom.rom_addr = '0;

    // ROM data belongs to the probe issued last cycle; out-of-range probes read as wall.
    if (prb_vld_q) begin
      shadow_d[prb_idx_q] = prb_rng_q ? rom.rom_data : WALL;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d  = ST_ISSUE;
          idx_d    = '0;
          snap_x_d = pos_x;
          snap_y_d = pos_y;
        end
      end
      ST_ISSUE: begin
        rom.rom_rd   = probe_in_range;
        rom.rom_addr = probe_addr;
        prb_vld_d    = 1'b1;
        if (idx_q == IDX_W'(N_PROBES - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_COMMIT;
      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        for (int unsigned m = 0; m < N_MOVERS; m++) begin
          map_l_d[m] = shadow_q[4*m];
          map_r_d[m] = shadow_q[4*m + 1];
          map_b_d[m] = shadow_q[4*m + 2];
          map_t_d[m] = shadow_q[4*m + 3];
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      snap_x_q  <= '0;
      snap_y_q  <= '0;
      prb_idx_q <= '0;
      prb_vld_q <= 1'b0;
      prb_rng_q <= 1'b0;
      shadow_q  <= {N_PROBES{WALL}};
      map_l_q   <= {N_MOVERS{WALL}};
      map_r_q   <= {N_MOVERS{WALL}};
      map_b_q   <= {N_MOVERS{WALL}};
      map_t_q   <= {N_MOVERS{WALL}};
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_x_q  <= snap_x_d;
      snap_y_q  <= snap_y_d;
      prb_idx_q <= prb_idx_d;
      prb_vld_q <= prb_vld_d;
      prb_rng_q <= prb_rng_d;
      shadow_q  <= shadow_d;
      map_l_q   <= map_l_d;
      map_r_q   <= map_r_d;
      map_b_q   <= map_b_d;
      map_t_q   <= map_t_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    map_l   = map_l_q;
    map_r   = map_r_q;
    map_b   = map_b_q;
    map_t   = map_t_q;
    done    = done_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_maze_probe_sched.sv
// Self-checking bench for maze_probe_sched: directed vector table, hand-built
// corner sequences and randomized scans against a pixel-level reference model.
module tb_maze_probe_sched;

  localparam int N = 5;

  typedef struct {
    int         x;
    int         y;
    logic [4:0] l;
    logic [4:0] r;
    logic [4:0] b;
    logic [4:0] t;
    logic [3:0] rd;
  } vec_t;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_start;
  logic [N-1:0][9:0] pos_x;
  logic [N-1:0][9:0] pos_y;
  logic [N-1:0][4:0] map_l, map_r, map_b, map_t;
  logic              busy, done, overrun;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rom_mode = 0;
  int         salt = 0;
  logic [9:0] addr_log [20];
  logic       rd_log   [20];

  maze_probe_sched_if rif ();

  maze_probe_sched #(
    .N_MOVERS  (N),
    .PROBE_OFS (14)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .rom         (rif),
    .map_l       (map_l),
    .map_r       (map_r),
    .map_b       (map_b),
    .map_t       (map_t),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [4:0] rom_fn(input int a);
    if (rom_mode == 0) return 5'(a % 32);
    return 5'((a * 13 + salt) % 23);
  endfunction

  // Synchronous ROM: data for the strobed address appears the following cycle.
  always @(posedge Clk) begin
    if (rif.rom_rd) rif.rom_data <= rom_fn(int'(rif.rom_addr));
  end

  // Reference: probe pixel from the mover centre, wall if off the 28x31 tile map.
  function automatic logic [4:0] model_probe(input int x, input int y, input int d);
    int px, py;
    px = x;
    py = y;
    case (d)
      0:       px = x - 14;
      1:       px = x + 14;
      2:       py = y + 14;
      default: py = y - 14;
    endcase
    if (px < 0 || py < 0 || px >= 28 * 16 || py >= 31 * 16) return 5'h1F;
    return rom_fn((py / 16) * 28 + px / 16);
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 20));
      1:       return int'($urandom_range(430, 500));
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_all(input int x, input int y);
    for (int m = 0; m < N; m++) begin
      pos_x[m] = 10'(x);
      pos_y[m] = 10'(y);
    end
  endtask

  // Starts a scan from the current negedge and returns at the negedge where done is seen.
  task automatic run_scan(input int ovr_at, input bit move_mid, output int done_edge,
                          output bit stable_ok, output bit bus_ok, output bit ovr_ok);
    logic [N-1:0][4:0] pl, pr, pb, pt;
    pl = map_l;
    pr = map_r;
    pb = map_b;
    pt = map_t;
    done_edge = -1;
    stable_ok = 1'b1;
    bus_ok    = 1'b1;
    ovr_ok    = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    addr_log[0] = rif.rom_addr;
    rd_log[0]   = rif.rom_rd;
    for (int e = 1; e <= 40; e++) begin
      @(negedge Clk);
      frame_start = (ovr_at == e + 1);
      if (e < 20) begin
        addr_log[e] = rif.rom_addr;
        rd_log[e]   = rif.rom_rd;
      end else if (rif.rom_rd !== 1'b0 || rif.rom_addr !== 10'd0) begin
        bus_ok = 1'b0;
      end
      if (overrun !== (e == ovr_at)) ovr_ok = 1'b0;
      if (done === 1'b1) begin
        done_edge = e;
        break;
      end
      if (map_l !== pl || map_r !== pr || map_b !== pb || map_t !== pt) stable_ok = 1'b0;
      if (move_mid && e == 3) begin
        for (int m = 0; m < N; m++) begin
          pos_x[m] = 10'($urandom_range(0, 1023));
          pos_y[m] = 10'($urandom_range(0, 1023));
        end
      end
    end
    frame_start = 1'b0;
  endtask

  initial begin
    vec_t       tbl [5];
    int         de;
    bit         st, bo, oo;
    int         extra;
    logic [4:0] exp_m [N][4];

    tbl[0] = '{x: 200, y: 250, l: 5'h0F, r: 5'h11, b: 5'h0C, t: 5'h14, rd: 4'b1111};
    tbl[1] = '{x: 10,  y: 250, l: 5'h1F, r: 5'h05, b: 5'h00, t: 5'h08, rd: 4'b1110};
    tbl[2] = '{x: 440, y: 250, l: 5'h1E, r: 5'h1F, b: 5'h1B, t: 5'h03, rd: 4'b1101};
    tbl[3] = '{x: 5,   y: 5,   l: 5'h1F, r: 5'h01, b: 5'h1C, t: 5'h1F, rd: 4'b0110};
    tbl[4] = '{x: 100, y: 490, l: 5'h0D, r: 5'h0F, b: 5'h1F, t: 5'h12, rd: 4'b1011};

    Reset_n     = 1'b1;
    frame_start = 1'b0;
    set_all(200, 250);

    // Asynchronous reset in the middle of a clock phase.
    #3 Reset_n = 1'b0;
    #1;
    check("rst_map_l", map_l, {N{5'h1F}});
    check("rst_map_t", map_t, {N{5'h1F}});
    check("rst_busy", busy, 0);
    check("rst_rom_rd", rif.rom_rd, 0);
    check("rst_rom_addr", rif.rom_addr, 0);
    check("rst_done", done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Directed table, scans chained back to back (each starts in the done cycle).
    for (int i = 0; i < 5; i++) begin
      set_all(tbl[i].x, tbl[i].y);
      if (i > 0) check($sformatf("b2b_done_cycle[%0d]", i), done, 1);
      run_scan(0, 1'b0, de, st, bo, oo);
      check($sformatf("done_edge[%0d]", i), de, 22);
      check($sformatf("map_l0[%0d]", i), map_l[0], tbl[i].l);
      check($sformatf("map_r0[%0d]", i), map_r[0], tbl[i].r);
      check($sformatf("map_b0[%0d]", i), map_b[0], tbl[i].b);
      check($sformatf("map_t0[%0d]", i), map_t[0], tbl[i].t);
      check($sformatf("map_l_last[%0d]", i), map_l[N-1], tbl[i].l);
      check($sformatf("map_t_last[%0d]", i), map_t[N-1], tbl[i].t);
      check($sformatf("rd_mask[%0d]", i), {rd_log[3], rd_log[2], rd_log[1], rd_log[0]}, tbl[i].rd);
      check($sformatf("stable[%0d]", i), st, 1);
      check($sformatf("bus_idle[%0d]", i), bo, 1);
      check($sformatf("no_overrun[%0d]", i), oo, 1);
    end

    // Issue address sequence for mover 0.
    set_all(200, 250);
    run_scan(0, 1'b0, de, st, bo, oo);
    check("addr_l", addr_log[0], 431);
    check("addr_r", addr_log[1], 433);
    check("addr_b", addr_log[2], 460);
    check("addr_t", addr_log[3], 404);
    check("addr_next_mover", addr_log[4], 431);

    // Second frame_start during a scan: dropped, flagged, single commit.
    set_all(100, 490);
    run_scan(5, 1'b0, de, st, bo, oo);
    check("ovr_done_edge", de, 22);
    check("ovr_pulse", oo, 1);
    check("ovr_map_l0", map_l[0], 5'h0D);
    check("ovr_map_b0", map_b[0], 5'h1F);
    extra = 0;
    repeat (10) begin
      @(negedge Clk);
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    check("ovr_single_commit", extra, 0);

    // Reset ten edges into a scan: no done, walls everywhere, then a clean scan.
    set_all(200, 250);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (10) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_map_l", map_l, {N{5'h1F}});
    check("midrst_map_r", map_r, {N{5'h1F}});
    check("midrst_busy", busy, 0);
    check("midrst_rom_rd", rif.rom_rd, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    extra = 0;
    repeat (30) begin
      @(negedge Clk);
      if (done !== 1'b0 || map_l !== {N{5'h1F}}) extra++;
    end
    check("midrst_no_commit", extra, 0);
    run_scan(0, 1'b0, de, st, bo, oo);
    check("postrst_done_edge", de, 22);
    check("postrst_map_r0", map_r[0], 5'h11);
    check("postrst_map_t4", map_t[N-1], 5'h14);

    // Randomized scans with positions scrambled mid-scan; model uses the snapshot.
    rom_mode = 1;
    for (int it = 0; it < 12; it++) begin
      salt = int'($urandom_range(0, 999));
      for (int m = 0; m < N; m++) begin
        pos_x[m] = 10'(pick());
        pos_y[m] = 10'(pick());
        for (int d = 0; d < 4; d++) exp_m[m][d] = model_probe(int'(pos_x[m]), int'(pos_y[m]), d);
      end
      run_scan(0, (it % 3) != 0, de, st, bo, oo);
      check($sformatf("rnd_done_edge[%0d]", it), de, 22);
      check($sformatf("rnd_stable[%0d]", it), st, 1);
      for (int m = 0; m < N; m++) begin
        check($sformatf("rnd_map_l[%0d][%0d]", it, m), map_l[m], exp_m[m][0]);
        check($sformatf("rnd_map_r[%0d][%0d]", it, m), map_r[m], exp_m[m][1]);
        check($sformatf("rnd_map_b[%0d][%0d]", it, m), map_b[m], exp_m[m][2]);
        check($sformatf("rnd_map_t[%0d][%0d]", it, m), map_t[m], exp_m[m][3]);
      end
    end

    repeat (3) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_probe_sched.md
MAZE_PROBE_SCHED -- requirements
Module: maze_probe_sched

Interface
REQ-001 Parameter N_MOVERS, default 5, number of movers (PacMan plus ghosts) sharing the maze ROM.
REQ-002 Parameter PROBE_OFS, default 14, pixel offset from mover centre to wall probe (mover size 13 + 1).
REQ-003 Clk  in  1  system clock; the only clock in the block.
REQ-004 Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 frame_start  in  1  one-cycle pulse, synchronous to Clk, requesting a scan.
REQ-006 pos_x  in  N_MOVERS x 10  mover centre X in pixels.
REQ-007 pos_y  in  N_MOVERS x 10  mover centre Y in pixels.
REQ-008 rom_addr  out  10  maze ROM tile address.
REQ-009 rom_rd  out  1  ROM read strobe.
REQ-010 rom_data  in  5  tile code, valid the cycle after rom_rd; 0 = free.
REQ-011 map_l, map_r, map_b, map_t  out  N_MOVERS x 5  committed tile code at each mover's left/right/bottom/top probe.
REQ-012 busy  out  1  scan in progress.
REQ-013 done  out  1  one-cycle pulse, new map_* values committed.
REQ-014 overrun  out  1  one-cycle pulse, frame_start dropped.

Function
REQ-015 FSM states IDLE, ISSUE, DRAIN, COMMIT; IDLE->ISSUE on frame_start; ISSUE->DRAIN after 4*N_MOVERS issue cycles; DRAIN->COMMIT->IDLE unconditionally.
REQ-016 On the edge leaving IDLE, all pos_x/pos_y are snapshotted; the scan uses only the snapshot.
REQ-017 Issue order: mover 0..N-1; per mover L, R, B, T; one probe per ISSUE cycle.
REQ-018 Probe pixel: L (x-PROBE_OFS, y), R (x+PROBE_OFS, y), B (x, y+PROBE_OFS), T (x, y-PROBE_OFS), computed 11 bits wide.
REQ-019 Address = (py >> TILE_SHIFT) * MAP_COLS + (px >> TILE_SHIFT), truncated to 10 bits.
REQ-020 Probe out of range (underflow, px >= MAP_COLS<<TILE_SHIFT, or py >= MAP_ROWS<<TILE_SHIFT): rom_rd low that cycle; result forced to WALL (5'h1F).
REQ-021 rom_data captured into a shadow register on the cycle after its issue; the in-range tag is pipelined alongside.
REQ-022 In COMMIT all shadow values copy to map_* together; map_* hold otherwise (atomic update).
REQ-023 done asserted exactly 4*N_MOVERS+2 rising edges after the edge sampling frame_start (22 for N=5).
REQ-024 busy high in ISSUE, DRAIN and COMMIT; low in IDLE.
REQ-025 frame_start while busy: ignored; overrun pulses next cycle; the scan in progress is unaffected.
REQ-026 frame_start in the cycle done is high is accepted (back-to-back scans).
REQ-027 rom_addr = 0 and rom_rd = 0 outside ISSUE.

Reset
REQ-028 Reset_n low asynchronously forces IDLE; map_* = WALL; busy, done, overrun, rom_rd = 0; rom_addr = 0; shadow = WALL.
REQ-029 Reset mid-scan aborts it: no done, no partial commit.

Structure
REQ-030 maze_pkg holds MAP_COLS=28, MAP_ROWS=31, TILE_SHIFT=4, WALL=5'h1F, the probe-direction enum (L, R, B, T) and the FSM state enum.
REQ-031 Sub-module maze_probe_addr (combinational): position, direction -> rom_addr plus in-range flag; instantiated once.

Verification
REQ-032 Reset: assert Reset_n=0 mid-clock -> immediately map_*=1F, busy=0, rom_rd=0.
REQ-033 Mover 0 at (200,250), ROM returns addr[4:0] -> rom_addr sequence 431, 433, 460, 404; map_l[0]=0F, map_r[0]=11, map_b[0]=0C, map_t[0]=14; done at edge 22.
REQ-034 Mover 0 at (10,250) and (440,250) -> L probe (first case) and R probe (second case) with rom_rd=0 in that probe's cycle; map_l[0] = 1F and map_r[0] = 1F respectively.
REQ-035 Second frame_start at edge 5 of a scan -> overrun pulse at edge 6; done still at edge 22; exactly one commit.
REQ-036 Reset_n low at edge 10 of a scan -> map_* = 1F, no done; next frame_start completes normally 22 edges later.
REQ-037 Change pos_x mid-scan and observe map_* every cycle -> map_* change only at the done edge and reflect the snapshot positions.
